// File: rtl/player_serial_pkg.sv
// Shared constants, FSM state encoding and the pLayer bit-destination helper for player_serial.
// Optional inverse permutation is enabled with the PLAYER_INV_EN macro.
package player_serial_pkg;

    localparam int DEF_WIDTH = 88;
    localparam int DEF_CHUNK = 8;
    localparam int N_SBOX    = DEF_WIDTH / 4;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        PERM  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Destination of source bit j; the top bit is always a fixed point.
    function automatic int perm_dest(input int j, input int width, input bit inv);
        if (j == width - 1) begin
            return j;
        end
        if (inv) begin
            return (4 * j) % (width - 1);
        end
        return (j * (width / 4)) % (width - 1);
    endfunction

endpackage

// File: rtl/player_serial_if.sv
// Stream bus of player_serial: CHUNK-bit input and output streams plus index/busy/state observation.
// Shared by both builds (PLAYER_INV_EN adds only a top-level port).
interface player_serial_if
    import player_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) ();

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Handshake: a word moves on a rising clk edge where valid && ready are both high.
    // The sender holds data and valid stable until that edge; ready may depend on state only.
    logic [CHUNK-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [CHUNK-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  chunk_idx;
    logic             busy;
    state_e           state;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, chunk_idx, busy, state
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, chunk_idx, busy, state
    );

endinterface

// File: rtl/player_perm.sv
// Combinational Spongent pLayer over the full WIDTH-bit state.
// With PLAYER_INV_EN defined an inv_i input selects the inverse permutation.
module player_perm
    import player_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data_i,
`ifdef PLAYER_INV_EN
    input  logic             inv_i,
`endif
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] fwd_w;

    for (genvar j = 0; j < WIDTH; j++) begin : g_fwd
        assign fwd_w[perm_dest(j, WIDTH, 1'b0)] = data_i[j];
    end

`ifdef PLAYER_INV_EN
    logic [WIDTH-1:0] inv_w;

    for (genvar j = 0; j < WIDTH; j++) begin : g_inv
        assign inv_w[perm_dest(j, WIDTH, 1'b1)] = data_i[j];
    end

    assign data_o = inv_i ? inv_w : fwd_w;
`else
    assign data_o = fwd_w;
`endif

endmodule

// File: rtl/player_serial.sv
// Streaming pLayer: loads NCHUNK words, permutes the whole state in one cycle, drains NCHUNK words.
// Defining PLAYER_INV_EN adds an inv port that selects the inverse permutation per state.
module player_serial
    import player_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic           clk,
    input  logic           rst,
`ifdef PLAYER_INV_EN
    input  logic           inv,
`endif
    player_serial_if.slave bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [WIDTH-1:0] perm_w;

`ifdef PLAYER_INV_EN
    logic inv_q;

    // inv is captured together with the final input word, i.e. on the edge entering PERM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inv_q <= 1'b0;
        end else if (state_q == LOAD && bus.in_valid && idx_q == LAST_IDX) begin
            inv_q <= inv;
        end
    end

    player_perm #(.WIDTH(WIDTH)) u_perm (
        .data_i (buf_q),
        .inv_i  (inv_q),
        .data_o (perm_w)
    );
`else
    player_perm #(.WIDTH(WIDTH)) u_perm (
        .data_i (buf_q),
        .data_o (perm_w)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        buf_d         = buf_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.busy      = 1'b0;
        case (state_q)
            LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    buf_d[idx_q*CHUNK +: CHUNK] = bus.in_data;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = PERM;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PERM: begin
                bus.busy = 1'b1;
                buf_d    = perm_w;
                state_d  = DRAIN;
            end
            DRAIN: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_data  = buf_q[idx_q*CHUNK +: CHUNK];
                if (bus.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
                idx_d   = '0;
            end
        endcase
    end

    assign bus.chunk_idx = idx_q;
    assign bus.state     = state_q;

endmodule
